cdb_wb_scheduler: RTL and testbench

//  Per-unit writeback queueing and CDB port scheduling. Each execution unit (ALU0, ALU1, BR, LSU)

---
 rtl/cdb_wb_scheduler_pkg.sv | 19 +
 rtl/cdb_wb_scheduler_if.sv | 32 +++
 rtl/cdb_wb_scheduler_queue.sv | 49 ++++
 rtl/cdb_wb_scheduler.sv | 110 +++++++++++
 tb/tb_cdb_wb_scheduler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_wb_scheduler_pkg.sv
// Shared types and default sizing for the CDB writeback scheduler.
// cdb_entry_t is the common payload carried by the RS/ROB/PRF broadcast ports.
package cdb_wb_scheduler_pkg;

  localparam int XLEN        = 32;
  localparam int LOG2_PREGS  = 6;
  localparam int PHYS_W      = LOG2_PREGS;
  localparam int ROB_W       = 6;
  localparam int NUM_SOURCES = 4;
  localparam int CDB_PORTS   = 2;
  localparam int Q_DEPTH     = 2;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [XLEN-1:0]   value;
    logic [ROB_W-1:0]  rob_tag;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_wb_scheduler_if.sv
// Writeback source handshake plus CDB broadcast bundle.
// The master side is the execution units / consumers; the scheduler is the slave.
interface cdb_wb_scheduler_if
  import cdb_wb_scheduler_pkg::*;
#(
  parameter int NUM_SOURCES = cdb_wb_scheduler_pkg::NUM_SOURCES,
  parameter int CDB_PORTS   = cdb_wb_scheduler_pkg::CDB_PORTS
);

  logic [NUM_SOURCES-1:0]             src_valid;
  logic [NUM_SOURCES-1:0]             src_ready;
  logic [NUM_SOURCES-1:0][PHYS_W-1:0] src_tag;
  logic [NUM_SOURCES-1:0][XLEN-1:0]   src_value;
  logic [NUM_SOURCES-1:0][ROB_W-1:0]  src_rob_tag;

  logic [CDB_PORTS-1:0]               cdb_valid;
  logic [CDB_PORTS-1:0][PHYS_W-1:0]   cdb_tag;
  logic [CDB_PORTS-1:0][XLEN-1:0]     cdb_value;
  logic [CDB_PORTS-1:0][ROB_W-1:0]    cdb_rob_tag;
  logic                               wb_pending;

  modport master (
    output src_valid, src_tag, src_value, src_rob_tag,
    input  src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag, wb_pending
  );

  modport slave (
    input  src_valid, src_tag, src_value, src_rob_tag,
    output src_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag, wb_pending
  );

endinterface

// File: rtl/cdb_wb_scheduler_queue.sv
// Shallow per-source writeback FIFO (wb_queue) with flush.
// Pointers wrap naturally because DEPTH is a power of two; count has one extra bit for full.
module cdb_wb_scheduler_queue
  import cdb_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  cdb_entry_t               data_i,
  output cdb_entry_t               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop_i)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  // Storage needs no reset: a slot is only read after the pointers say it was written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/cdb_wb_scheduler.sv
// Per-unit writeback queues feeding CDB_PORTS broadcast ports with round-robin arbitration.
// The scan starts at rrPtr_q and the pointer moves just past the last source granted.
module cdb_wb_scheduler
  import cdb_wb_scheduler_pkg::*;
#(
  parameter int CDB_PORTS   = cdb_wb_scheduler_pkg::CDB_PORTS,
  parameter int NUM_SOURCES = cdb_wb_scheduler_pkg::NUM_SOURCES,
  parameter int Q_DEPTH     = cdb_wb_scheduler_pkg::Q_DEPTH
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  cdb_wb_scheduler_if.slave  bus
);

  localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int PORT_W = (CDB_PORTS > 1) ? $clog2(CDB_PORTS) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  cdb_entry_t             srcEntry [NUM_SOURCES];
  cdb_entry_t             qHead    [NUM_SOURCES];
  logic [CNT_W-1:0]       qCount   [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] qFull;
  logic [NUM_SOURCES-1:0] qEmpty;
  logic [NUM_SOURCES-1:0] srcReady;
  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] grant;

  logic [SRC_W-1:0]       rrPtr_q;
  logic [SRC_W-1:0]       rrPtr_d;
  logic [SRC_W-1:0]       srcIdx;
  logic [SRC_W-1:0]       lastSrc;
  logic [PORT_W-1:0]      portIdx;
  int                     portCnt;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_queue
    assign srcEntry[i] = '{tag: bus.src_tag[i], value: bus.src_value[i], rob_tag: bus.src_rob_tag[i]};

    cdb_wb_scheduler_queue #(.DEPTH(Q_DEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (push[i]),
      .pop_i   (grant[i]),
      .data_i  (srcEntry[i]),
      .data_o  (qHead[i]),
      .count_o (qCount[i]),
      .full_o  (qFull[i]),
      .empty_o (qEmpty[i])
    );

    a_countBound : assert property (@(posedge clk) disable iff (reset)
      qCount[i] <= CNT_W'(Q_DEPTH));
  end

  // Ready is from registered occupancy only, so a pop this cycle never frees a slot early.
  assign srcReady       = ~qFull & {NUM_SOURCES{~flush}};
  assign push           = bus.src_valid & srcReady;
  assign bus.src_ready  = srcReady;
  assign bus.wb_pending = |(~qEmpty);

  always_comb begin
    grant           = '0;
    bus.cdb_valid   = '0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.cdb_rob_tag = '0;
    portCnt         = 0;
    portIdx         = '0;
    srcIdx          = rrPtr_q;
    lastSrc         = rrPtr_q;
    if (!flush) begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        srcIdx = SRC_W'((int'(rrPtr_q) + k) % NUM_SOURCES);
        if (!qEmpty[srcIdx] && (portCnt < CDB_PORTS)) begin
          portIdx                  = PORT_W'(portCnt);
          grant[srcIdx]            = 1'b1;
          bus.cdb_valid[portIdx]   = 1'b1;
          bus.cdb_tag[portIdx]     = qHead[srcIdx].tag;
          bus.cdb_value[portIdx]   = qHead[srcIdx].value;
          bus.cdb_rob_tag[portIdx] = qHead[srcIdx].rob_tag;
          lastSrc                  = srcIdx;
          portCnt                  = portCnt + 1;
        end
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (flush) begin
      rrPtr_d = '0;
    end else if (grant != '0) begin
      rrPtr_d = SRC_W'((int'(lastSrc) + 1) % NUM_SOURCES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rrPtr_q <= '0;
    else       rrPtr_q <= rrPtr_d;
  end

  a_pushOnlyWhenReady : assert property (@(posedge clk) disable iff (reset)
    (push & ~srcReady) == '0);
  a_oneGrantPerPort : assert property (@(posedge clk) disable iff (reset)
    $countones(grant) == $countones(bus.cdb_valid));
  a_portsPacked : assert property (@(posedge clk) disable iff (reset)
    (bus.cdb_valid & (bus.cdb_valid + 1'b1)) == '0);

endmodule

// File: tb/tb_cdb_wb_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// Tags encode the source in their top two bits so grants can be attributed from the CDB alone.
module tb_cdb_wb_scheduler;
  import cdb_wb_scheduler_pkg::*;

  localparam int NS = NUM_SOURCES;
  localparam int NP = CDB_PORTS;
  localparam int QD = Q_DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic flushDrv;

  always #5 clk = ~clk;

  cdb_wb_scheduler_if #(.NUM_SOURCES(NS), .CDB_PORTS(NP)) bus ();

  cdb_wb_scheduler #(.CDB_PORTS(NP), .NUM_SOURCES(NS), .Q_DEPTH(QD)) dut (
    .clk   (clk),
    .reset (rst),
    .flush (flushDrv),
    .bus   (bus)
  );

  int compareCnt  = 0;
  int mismatchCnt = 0;

  cdb_entry_t    modelQ [NS][$];
  int            modelRr;
  logic [NS-1:0] expReady;
  int            nGrant;
  int            grantSrc [NP];

  logic [NS-1:0] snapReady;
  logic [NP-1:0] snapValid;
  logic          snapPending;
  logic [63:0]   snapPort [NP];

  int grantTally [NS];
  bit tallyEn = 1'b0;
  int seq = 0;

  function automatic logic [63:0] packEntry(input cdb_entry_t e);
    return 64'({e.tag, e.rob_tag, e.value});
  endfunction

  function automatic logic [63:0] obsPort(input int p);
    return 64'({bus.cdb_tag[p], bus.cdb_rob_tag[p], bus.cdb_value[p]});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCnt++;
    if (obs !== exp) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setOffer(input int s, input logic [5:0] tag, input logic [31:0] val, input logic [5:0] rob);
    bus.src_valid[s]   = 1'b1;
    bus.src_tag[s]     = tag;
    bus.src_value[s]   = val;
    bus.src_rob_tag[s] = rob;
  endtask

  task automatic applyStimulus(input int pctValid, input int pctFlush, input int pctReset);
    for (int s = 0; s < NS; s++) begin
      if (!bus.src_valid[s] && ($urandom_range(99) < pctValid)) begin
        setOffer(s, 6'({2'(s), 4'(seq)}), $urandom, 6'($urandom_range(63)));
        seq++;
      end
    end
    flushDrv = ($urandom_range(99) < pctFlush);
    rst      = ($urandom_range(99) < pctReset);
  endtask

  // Called right after a negedge with inputs settled; returns at the following negedge.
  task automatic runCycle();
    logic [NP-1:0] expValid;
    logic [63:0]   expPort [NP];
    logic          expPending;
    int            s;
    cdb_entry_t    e;
    #1;
    expValid   = '0;
    expPending = 1'b0;
    nGrant     = 0;
    for (int p = 0; p < NP; p++) expPort[p] = '0;
    for (int i = 0; i < NS; i++) begin
      expReady[i] = (modelQ[i].size() < QD) && !flushDrv;
      if (modelQ[i].size() > 0) expPending = 1'b1;
    end
    if (!flushDrv) begin
      for (int k = 0; k < NS; k++) begin
        s = (modelRr + k) % NS;
        if (modelQ[s].size() > 0 && nGrant < NP) begin
          expPort[nGrant]  = packEntry(modelQ[s][0]);
          expValid[nGrant] = 1'b1;
          grantSrc[nGrant] = s;
          nGrant++;
        end
      end
    end
    checkOutput("src_ready", 64'(bus.src_ready), 64'(expReady));
    checkOutput("wb_pending", 64'(bus.wb_pending), 64'(expPending));
    checkOutput("cdb_valid", 64'(bus.cdb_valid), 64'(expValid));
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("cdb_port%0d", p), obsPort(p), expPort[p]);
      snapPort[p] = obsPort(p);
      if (tallyEn && bus.cdb_valid[p]) grantTally[bus.cdb_tag[p][5:4]]++;
    end
    snapReady   = bus.src_ready;
    snapValid   = bus.cdb_valid;
    snapPending = bus.wb_pending;

    @(posedge clk);
    #1;
    if (rst || flushDrv) begin
      for (int i = 0; i < NS; i++) modelQ[i].delete();
      modelRr = 0;
    end else begin
      for (int g = 0; g < nGrant; g++) void'(modelQ[grantSrc[g]].pop_front());
      if (nGrant > 0) modelRr = (grantSrc[nGrant-1] + 1) % NS;
    end
    for (int i = 0; i < NS; i++) begin
      if (bus.src_valid[i] && expReady[i]) begin
        e = '{tag: bus.src_tag[i], value: bus.src_value[i], rob_tag: bus.src_rob_tag[i]};
        if (!(rst || flushDrv)) modelQ[i].push_back(e);
        bus.src_valid[i] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
  endtask

  logic [5:0] s3Tags [$];
  int         s3Sent;

  initial begin
    bus.src_valid   = '0;
    bus.src_tag     = '0;
    bus.src_value   = '0;
    bus.src_rob_tag = '0;
    flushDrv        = 1'b0;
    rst             = 1'b1;
    modelRr         = 0;
    @(posedge clk);
    #1;
    @(negedge clk);

    // Reset state
    resetCycle();
    checkOutput("reset_ready", 64'(snapReady), 64'hF);
    checkOutput("reset_valid", 64'(snapValid), 64'h0);
    checkOutput("reset_pending", 64'(snapPending), 64'h0);
    checkOutput("reset_port0", snapPort[0], 64'h0);

    // Scenario 1: single ALU0 result
    setOffer(0, 6'd5, 32'h11, 6'd3);
    runCycle();
    checkOutput("s1_t0_valid", 64'(snapValid), 64'h0);
    runCycle();
    checkOutput("s1_t1_valid", 64'(snapValid), 64'h1);
    checkOutput("s1_t1_port0", snapPort[0], 64'({6'd5, 6'd3, 32'h11}));
    checkOutput("s1_t1_port1", snapPort[1], 64'h0);
    checkOutput("s1_t1_pending", 64'(snapPending), 64'h1);
    runCycle();
    checkOutput("s1_t2_pending", 64'(snapPending), 64'h0);

    // Scenario 2 then 6: all sources push once, reset lands at t3
    resetCycle();
    for (int i = 0; i < NS; i++) setOffer(i, 6'({2'(i), 4'h0}), 32'h100 + 32'(i), 6'(i));
    runCycle();
    runCycle();
    checkOutput("s2_t1_valid", 64'(snapValid), 64'h3);
    checkOutput("s2_t1_port0", snapPort[0], 64'({6'h00, 6'd0, 32'h100}));
    checkOutput("s2_t1_port1", snapPort[1], 64'({6'h10, 6'd1, 32'h101}));
    runCycle();
    checkOutput("s2_t2_port0", snapPort[0], 64'({6'h20, 6'd2, 32'h102}));
    checkOutput("s2_t2_port1", snapPort[1], 64'({6'h30, 6'd3, 32'h103}));
    checkOutput("s2_rr_after_t2", 64'(dut.rrPtr_q), 64'h0);
    for (int i = 0; i < NS; i++) setOffer(i, 6'({2'(i), 4'h1}), 32'h200 + 32'(i), 6'(i));
    rst = 1'b1;
    runCycle();
    rst = 1'b0;
    bus.src_valid = '0;
    runCycle();
    checkOutput("s6_ready", 64'(snapReady), 64'hF);
    checkOutput("s6_valid", 64'(snapValid), 64'h0);
    checkOutput("s6_pending", 64'(snapPending), 64'h0);
    checkOutput("s6_rr", 64'(dut.rrPtr_q), 64'h0);

    // Scenario 3: ALU1 streams three results
    resetCycle();
    s3Sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (!bus.src_valid[1] && s3Sent < 3) begin
        setOffer(1, 6'h18 + 6'(s3Sent), 32'hA0 + 32'(s3Sent), 6'(s3Sent));
        s3Sent++;
      end
      runCycle();
      if (snapValid[0]) s3Tags.push_back(snapPort[0][43:38]);
    end
    checkOutput("s3_count", 64'(s3Tags.size()), 64'd3);
    for (int i = 0; i < s3Tags.size() && i < 3; i++)
      checkOutput($sformatf("s3_order%0d", i), 64'(s3Tags[i]), 64'(6'h18 + 6'(i)));

    // Scenario 4: fairness with every queue kept busy
    resetCycle();
    for (int i = 0; i < NS; i++) grantTally[i] = 0;
    for (int i = 0; i < NS; i++) setOffer(i, 6'({2'(i), 4'(seq)}), $urandom, 6'(i));
    runCycle();
    tallyEn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NS; i++)
        if (!bus.src_valid[i]) setOffer(i, 6'({2'(i), 4'(c)}), $urandom, 6'(i));
      runCycle();
    end
    tallyEn = 1'b0;
    bus.src_valid = '0;
    for (int i = 0; i < NS; i++) checkOutput($sformatf("s4_grants_src%0d", i), 64'(grantTally[i]), 64'd4);

    // Scenario 5: flush with three queues occupied
    resetCycle();
    for (int i = 0; i < 3; i++) setOffer(i, 6'({2'(i), 4'h7}), 32'h300 + 32'(i), 6'(i));
    runCycle();
    flushDrv = 1'b1;
    runCycle();
    flushDrv = 1'b0;
    checkOutput("s5_flush_valid", 64'(snapValid), 64'h0);
    checkOutput("s5_flush_pending", 64'(snapPending), 64'h1);
    runCycle();
    checkOutput("s5_after_ready", 64'(snapReady), 64'hF);
    checkOutput("s5_after_pending", 64'(snapPending), 64'h0);
    checkOutput("s5_after_valid", 64'(snapValid), 64'h0);

    // Random traffic with occasional flush and reset
    resetCycle();
    for (int c = 0; c < 600; c++) begin
      applyStimulus(60, 4, 1);
      runCycle();
    end
    flushDrv = 1'b0;
    rst      = 1'b0;
    for (int c = 0; c < 8; c++) runCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
